// File: rtl/remote_controller.sv
// remote_controller
//   Serial receiver/decoder for an infrared-style remote-control frame, one bit per clk.
//   A frame is a start pattern (serial low for one or more cycles, then high for one
//   cycle) followed by 32 data bits, MSB first: custom[15:0], key[7:0], inv_key[7:0].
//   A frame is accepted when the custom code matches CUSTOM_CODE and inv_key is the
//   bitwise complement of key. An accepted key is published on remote_key together
//   with a one-cycle ready strobe.
//
// Ports
//   clk         in   1  system clock; serial sampled on rising edge
//   reset       in   1  asynchronous, active-low reset
//   serial      in   1  serial frame input, idle high, synchronous to clk
//   ready       out  1  one-cycle strobe: remote_key was just updated with a valid key
//   remote_key  out  8  last validly decoded key code, held until the next valid frame

module remote_controller #(
    parameter logic [15:0] CUSTOM_CODE = 16'hAAAA
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial,
    output logic       ready,
    output logic [7:0] remote_key
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StCustom,
        StKey,
        StInv
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    // Holds the first 31 data bits of the frame; the 32nd is taken straight from serial.
    logic [30:0] shift_q, shift_d;
    logic        ready_q, ready_d;
    logic [7:0]  remote_key_q, remote_key_d;

    logic [31:0] frame;
    logic        frame_valid;

    // Complete frame as seen on the edge that samples the last inv_key bit.
    assign frame       = {shift_q, serial};
    assign frame_valid = ((frame[15:8] ^ frame[7:0]) == 8'hFF) &&
                         (frame[31:16] == CUSTOM_CODE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 31'd0;
            ready_q      <= 1'b0;
            remote_key_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            ready_q      <= ready_d;
            remote_key_q <= remote_key_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        ready_d      = 1'b0;
        remote_key_d = remote_key_q;

        unique case (state_q)
            StIdle: begin
                if (!serial) begin
                    state_d = StStart;
                end
            end

            StStart: begin
                // Low phase of any length is accepted; the first high bit ends the start.
                if (serial) begin
                    state_d   = StCustom;
                    bit_cnt_d = 4'd0;
                end
            end

            StCustom: begin
                shift_d = {shift_q[29:0], serial};
                if (bit_cnt_q == 4'd15) begin
                    state_d   = StKey;
                    bit_cnt_d = 4'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end

            StKey: begin
                shift_d = {shift_q[29:0], serial};
                if (bit_cnt_q == 4'd7) begin
                    state_d   = StInv;
                    bit_cnt_d = 4'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end

            StInv: begin
                if (bit_cnt_q == 4'd7) begin
                    state_d   = StIdle;
                    bit_cnt_d = 4'd0;
                    if (frame_valid) begin
                        ready_d      = 1'b1;
                        remote_key_d = frame[15:8];
                    end
                end else begin
                    shift_d   = {shift_q[29:0], serial};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end

            default: begin
                state_d   = StIdle;
                bit_cnt_d = 4'd0;
            end
        endcase
    end

    assign ready      = ready_q;
    assign remote_key = remote_key_q;

endmodule

// File: tb/tb_remote_controller.sv
// tb_remote_controller
//   Directed bench for remote_controller. Serial bits are driven on the falling edge and
//   outputs are sampled 1 time unit after the rising edge that consumes them.

module tb_remote_controller;

    logic       clk;
    logic       reset;
    logic       serial;
    logic       ready;
    logic [7:0] remote_key;

    int checks;
    int errors;

    remote_controller #(
        .CUSTOM_CODE(16'hAAAA)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .serial     (serial),
        .ready      (ready),
        .remote_key (remote_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        serial = b;
        @(posedge clk);
        #1;
    endtask

    // Sends start (low_cycles zeros, then a one) and 32 data bits. Checks that ready is
    // still low just before the last bit, then checks ready/remote_key on the last bit
    // and that ready drops one cycle later (serial returns high).
    task automatic send_frame(input string tag, input int low_cycles,
                              input logic [15:0] custom, input logic [7:0] key,
                              input logic [7:0] inv, input logic exp_ready,
                              input logic [7:0] exp_key);
        logic [31:0] word;
        word = {custom, key, inv};
        for (int i = 0; i < low_cycles; i++) send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 31; i > 0; i--) send_bit(word[i]);
        check_eq({tag, "_ready_early"}, {15'd0, ready}, 16'd0);
        send_bit(word[0]);
        check_eq({tag, "_ready"}, {15'd0, ready}, {15'd0, exp_ready});
        check_eq({tag, "_key"}, {8'd0, remote_key}, {8'd0, exp_key});
        send_bit(1'b1);
        check_eq({tag, "_ready_drop"}, {15'd0, ready}, 16'd0);
        check_eq({tag, "_key_hold"}, {8'd0, remote_key}, {8'd0, exp_key});
    endtask

    initial begin
        logic [31:0] word;
        checks = 0;
        errors = 0;
        serial = 1'b1;
        reset  = 1'b0;

        // 1: reset state, then idle with serial high
        #12;
        check_eq("rst_ready", {15'd0, ready}, 16'd0);
        check_eq("rst_key", {8'd0, remote_key}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        check_eq("idle_ready", {15'd0, ready}, 16'd0);
        check_eq("idle_key", {8'd0, remote_key}, 16'h0000);

        // 2: valid frame
        send_frame("valid81", 1, 16'hAAAA, 8'h81, 8'h7E, 1'b1, 8'h81);

        // 3: inverse mismatch
        send_frame("badinv", 1, 16'hAAAA, 8'h89, 8'h7E, 1'b0, 8'h81);

        // 4: wrong custom code
        send_frame("badcust", 1, 16'h5555, 8'h81, 8'h7E, 1'b0, 8'h81);

        // 5: long start low
        send_frame("longlow", 5, 16'hAAAA, 8'h3C, 8'hC3, 1'b1, 8'h3C);

        // back-to-back: next start low immediately after last bit
        word = {16'hAAAA, 8'h55, 8'hAA};
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 31; i >= 0; i--) send_bit(word[i]);
        check_eq("b2b_ready", {15'd0, ready}, 16'd1);
        check_eq("b2b_key", {8'd0, remote_key}, 16'h0055);
        send_frame("b2b_next", 1, 16'hAAAA, 8'h3C, 8'hC3, 1'b1, 8'h3C);

        // 6: reset in the middle of the key field
        word = {16'hAAAA, 8'h81, 8'h7E};
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 31; i > 12; i--) send_bit(word[i]);
        #2;
        reset = 1'b0;
        #1;
        check_eq("midrst_ready", {15'd0, ready}, 16'd0);
        check_eq("midrst_key", {8'd0, remote_key}, 16'h0000);
        @(negedge clk);
        serial = 1'b1;
        reset  = 1'b1;
        send_bit(1'b1);
        send_frame("postrst", 1, 16'hAAAA, 8'h81, 8'h7E, 1'b1, 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
